shift_pipe: RTL and testbench

Parametrised, optionally pipelined barrel shifter for the execute stage. Supports logical left, logical right, arithmetic right, rotate left and rotate right over a configurable data width. A valid/ready handshake with per-stage stall lets it sit in the EX path of the 5-stage core or behind a multi-cycle functional-unit arbiter. A flush input kills all in-flight operations on branch redirect.

---
 rtl/shift_pkg.sv | 35 +++
 rtl/shift_level.sv | 36 +++
 rtl/shift_pipe.sv | 132 +++++++++++++
 tb/tb_shift_pipe.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared definitions for the shift_pipe barrel shifter.
//   shift_op_e    : 3-bit operation code. Codes 5..7 are reserved.
//   f_reg_after   : level index that pipeline register k follows.
//   f_stage_at    : inverse lookup. Returns the register number after a level,
//                   or 0 when that level is not followed by a register.
//   f_is_reserved : true for the unused operation codes.
package shift_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    // ceil(k*levels/p) - 1, in integer arithmetic.
    function automatic int f_reg_after(input int k, input int levels, input int p);
        return (k * levels + p - 1) / p - 1;
    endfunction

    // Registers land on distinct levels whenever p <= levels,
    // so the first match is the only match.
    function automatic int f_stage_at(input int lvl, input int levels, input int p);
        for (int k = 1; k <= p; k++) begin
            if (f_reg_after(k, levels, p) == lvl) return k;
        end
        return 0;
    endfunction

    function automatic logic f_is_reserved(input logic [2:0] op);
        return op > 3'd4;
    endfunction

endpackage

// File: rtl/shift_level.sv
// One combinational level of the log shifter. It shifts or rotates by DIST
// when en_i is set, and otherwise passes the data through unchanged.
//   data_i : partial result from the previous level
//   op_i   : operation selecting the fill rule
//   sign_i : sign bit captured from the original operand (SRA fill)
//   en_i   : amount bit for this level
//   data_o : partial result for the next level
module shift_level
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  shift_op_e        op_i,
    input  logic             sign_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        // NOTE: default assignment first so every path drives data_o; no latch.
        data_o = data_i;
        if (en_i) begin
            case (op_i)
                OP_SLL:  data_o = data_i << DIST;
                OP_SRL:  data_o = data_i >> DIST;
                OP_SRA:  data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
                OP_ROL:  data_o = {data_i[WIDTH-1-DIST:0], data_i[WIDTH-1:WIDTH-DIST]};
                OP_ROR:  data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
                default: data_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Parametrised, optionally pipelined barrel shifter with a valid/ready
// handshake and flush.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_flush          : kill all in-flight operations and the one at the input
//   i_valid/o_ready  : upstream handshake
//   i_op, i_data, i_amt, i_tag : operation, operand, amount, sideband tag
//   o_valid/i_ready  : downstream handshake
//   o_data, o_tag    : result and its tag
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 5
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_flush,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [2:0]               i_op,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [$clog2(WIDTH)-1:0] i_amt,
    input  logic [TAG_W-1:0]         i_tag,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [WIDTH-1:0]         o_data,
    output logic [TAG_W-1:0]         o_tag
);

    localparam int AMT_W  = $clog2(WIDTH);
    localparam int LEVELS = AMT_W;
    localparam int NREG   = (PIPE_STAGES == 0) ? 1 : PIPE_STAGES;

    typedef struct packed {
        logic             valid;
        logic [2:0]       op;
        logic [AMT_W-1:0] amt;
        logic             sign;
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } stage_t;

    function automatic stage_t f_with_data(input stage_t s, input logic [WIDTH-1:0] d);
        stage_t r;
        r      = s;
        r.data = d;
        return r;
    endfunction

    stage_t           lvl_in  [LEVELS+1];  // lvl_in[j] feeds level j, lvl_in[LEVELS] is the output
    stage_t           lvl_out [LEVELS];
    logic [WIDTH-1:0] lvl_dat [LEVELS];
    stage_t           stg_q   [NREG];

    // Reserved ops zero the operand at entry. Every level then only moves
    // zeros around, so the result is 0 for any amount.
    assign lvl_in[0] = '{
        valid: i_valid,
        op:    i_op,
        amt:   i_amt,
        sign:  i_data[WIDTH-1],
        data:  f_is_reserved(i_op) ? {WIDTH{1'b0}} : i_data,
        tag:   i_tag
    };

    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        localparam int STG = f_stage_at(j, LEVELS, PIPE_STAGES);

        shift_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << j)
        ) u_level (
            .data_i (lvl_in[j].data),
            .op_i   (shift_op_e'(lvl_in[j].op)),
            .sign_i (lvl_in[j].sign),
            .en_i   (lvl_in[j].amt[j]),
            .data_o (lvl_dat[j])
        );

        assign lvl_out[j] = f_with_data(lvl_in[j], lvl_dat[j]);

        if (STG != 0) begin : g_reg
            assign lvl_in[j+1] = stg_q[STG-1];
        end else begin : g_wire
            assign lvl_in[j+1] = lvl_out[j];
        end
    end

    if (PIPE_STAGES == 0) begin : g_comb
        assign stg_q[0] = '0;
        assign o_ready  = i_ready;
        assign o_valid  = i_valid && !i_flush;
    end else begin : g_pipe
        logic [PIPE_STAGES-1:0] rdy;

        // A stage accepts when it is empty or its occupant moves on this
        // cycle. The chain runs from i_ready back to o_ready, so bubbles collapse.
        always_comb begin
            logic nxt;
            nxt = i_ready;
            for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
                nxt    = !stg_q[s].valid || nxt;
                rdy[s] = nxt;
            end
        end

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                // NOTE: the payload is reset as well as valid, because o_data and o_tag must read zero in reset.
                for (int s = 0; s < PIPE_STAGES; s++) stg_q[s] <= '0;
            end else begin
                // NOTE: non-blocking assignments, so each stage samples its neighbour's pre-edge value.
                for (int s = 0; s < PIPE_STAGES; s++) begin
                    if (i_flush) begin
                        stg_q[s].valid <= 1'b0;
                    end else if (rdy[s]) begin
                        stg_q[s] <= lvl_out[f_reg_after(s + 1, LEVELS, PIPE_STAGES)];
                    end
                end
            end
        end

        assign o_ready = rdy[0];
        assign o_valid = lvl_in[LEVELS].valid;
    end

    // With registers, the last one sits after the final level, so lvl_in[LEVELS] is that register.
    assign o_data = lvl_in[LEVELS].data;
    assign o_tag  = lvl_in[LEVELS].tag;

endmodule

// File: tb/tb_shift_pipe.sv
module tb_shift_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_data;
    logic [4:0]  in_amt;
    logic [4:0]  in_tag;
    logic        cons_ready;
    logic [63:0] in_data64;
    logic [5:0]  in_amt64;

    logic        out_ready, out_valid;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        p0_ready, p0_valid;
    logic [31:0] p0_data;
    logic [4:0]  p0_tag;
    logic        p5_ready, p5_valid;
    logic [31:0] p5_data;
    logic [4:0]  p5_tag;
    logic        w64_ready, w64_valid;
    logic [63:0] w64_data;
    logic [4:0]  w64_tag;

    int total = 0;
    int bad   = 0;

    shift_pipe #(.WIDTH(32), .PIPE_STAGES(2), .TAG_W(5)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(out_ready),
        .i_op(in_op), .i_data(in_data), .i_amt(in_amt), .i_tag(in_tag),
        .o_valid(out_valid), .i_ready(cons_ready), .o_data(out_data), .o_tag(out_tag));

    shift_pipe #(.WIDTH(32), .PIPE_STAGES(0), .TAG_W(5)) dut_p0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(p0_ready),
        .i_op(in_op), .i_data(in_data), .i_amt(in_amt), .i_tag(in_tag),
        .o_valid(p0_valid), .i_ready(cons_ready), .o_data(p0_data), .o_tag(p0_tag));

    shift_pipe #(.WIDTH(32), .PIPE_STAGES(5), .TAG_W(5)) dut_p5 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(p5_ready),
        .i_op(in_op), .i_data(in_data), .i_amt(in_amt), .i_tag(in_tag),
        .o_valid(p5_valid), .i_ready(cons_ready), .o_data(p5_data), .o_tag(p5_tag));

    shift_pipe #(.WIDTH(64), .PIPE_STAGES(1), .TAG_W(5)) dut_w64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_valid(in_valid), .o_ready(w64_ready),
        .i_op(in_op), .i_data(in_data64), .i_amt(in_amt64), .i_tag(in_tag),
        .o_valid(w64_valid), .i_ready(cons_ready), .o_data(w64_data), .o_tag(w64_tag));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] d,
                         input logic [4:0] a, input logic [4:0] t);
        in_valid = v;
        in_op    = op;
        in_data  = d;
        in_amt   = a;
        in_tag   = t;
    endtask

    task automatic test_reset();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL reset_tag got=%h want=0", out_tag); end
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", out_ready); end
    endtask

    task automatic test_directed_ops();
        logic [31:0] exp_d [7];
        logic [2:0]  ops   [7];
        logic [4:0]  amts  [7];
        exp_d = '{32'h0000_0F10, 32'h0800_000F, 32'hF800_000F, 32'h0000_0F18, 32'h1800_000F,
                  32'h0000_0000, 32'h8000_00F1};
        ops   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6, 3'd2};
        amts  = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd0};
        cons_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, ops[i], 32'h8000_00F1, amts[i], 5'(i + 1));
            total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL op%0d_ready got=%b want=1", i, out_ready); end
            tick();
            in_valid = 1'b0;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL op%0d_early got=%b want=0", i, out_valid); end
            tick();
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_tag !== 5'(i + 1)) begin
                bad++;
                $display("FAIL op%0d_result got=%b/%h/%h want=1/%h/%h", i, out_valid, out_data, out_tag,
                         exp_d[i], 5'(i + 1));
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ops  [8];
        logic [31:0] dats [8];
        logic [4:0]  amts [8];
        logic [31:0] exps [8];
        ops  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd2, 3'd3, 3'd0};
        dats = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_0000, 32'h1234_5678, 32'h1234_5678,
                 32'h7FFF_FFFF, 32'h8000_0001, 32'hDEAD_BEEF};
        amts = '{5'd31, 5'd31, 5'd31, 5'd8, 5'd8, 5'd1, 5'd1, 5'd0};
        exps = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h3456_7812, 32'h7812_3456,
                 32'h3FFF_FFFF, 32'h0000_0003, 32'hDEAD_BEEF};
        cons_ready = 1'b1;
        for (int n = 0; n < 11; n++) begin
            if (n < 8) drive(1'b1, ops[n], dats[n], amts[n], 5'(16 + n));
            else in_valid = 1'b0;
            if (n >= 2 && n < 10) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== exps[n-2] || out_tag !== 5'(14 + n)) begin
                    bad++;
                    $display("FAIL b2b_%0d got=%b/%h/%h want=1/%h/%h", n - 2, out_valid, out_data, out_tag,
                             exps[n-2], 5'(14 + n));
                end
            end else begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle%0d got=%b want=0", n, out_valid); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        cons_ready = 1'b0;
        drive(1'b1, 3'd0, 32'h0000_0001, 5'd1, 5'd1);
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL bp_rdy0 got=%b want=1", out_ready); end
        tick();
        drive(1'b1, 3'd1, 32'h0000_0100, 5'd4, 5'd2);
        total++; if (out_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_rdy1 got=%b/%b want=1/0", out_ready, out_valid); end
        tick();
        drive(1'b1, 3'd4, 32'h0000_0003, 5'd1, 5'd3);
        for (int c = 2; c < 5; c++) begin
            total++;
            if (out_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 32'h2 || out_tag !== 5'd1) begin
                bad++;
                $display("FAIL bp_hold%0d got=%b/%b/%h/%h want=0/1/00000002/01", c, out_ready, out_valid, out_data, out_tag);
            end
            tick();
        end
        cons_ready = 1'b1;
        #1;
        total++; if (out_ready !== 1'b1 || out_data !== 32'h2) begin bad++; $display("FAIL bp_release got=%b/%h want=1/00000002", out_ready, out_data); end
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h10 || out_tag !== 5'd2) begin bad++; $display("FAIL bp_drain_b got=%b/%h/%h want=1/00000010/02", out_valid, out_data, out_tag); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h8000_0001 || out_tag !== 5'd3) begin bad++; $display("FAIL bp_drain_c got=%b/%h/%h want=1/80000001/03", out_valid, out_data, out_tag); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_nodup got=%b want=0", out_valid); end
    endtask

    task automatic test_flush();
        cons_ready = 1'b1;
        drive(1'b1, 3'd0, 32'h0000_0011, 5'd1, 5'd7);
        tick();
        drive(1'b1, 3'd0, 32'h0000_0022, 5'd1, 5'd8);
        tick();
        drive(1'b1, 3'd0, 32'h0000_0033, 5'd1, 5'd9);
        flush = 1'b1;
        #1;
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b want=1", out_ready); end
        total++; if (out_valid !== 1'b1 || out_data !== 32'h22 || out_tag !== 5'd7) begin bad++; $display("FAIL flush_xfer got=%b/%h/%h want=1/00000022/07", out_valid, out_data, out_tag); end
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_gone%0d got=%b/%h want=0", c, out_valid, out_tag); end
            tick();
        end
    endtask

    task automatic test_async_reset();
        cons_ready = 1'b1;
        drive(1'b1, 3'd0, 32'h0000_0001, 5'd3, 5'd4);
        tick();
        drive(1'b1, 3'd1, 32'h0000_0080, 5'd1, 5'd5);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || out_data !== 32'h8) begin bad++; $display("FAIL rst_pre got=%b/%h want=1/00000008", out_valid, out_data); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0) begin bad++; $display("FAIL rst_async got=%b/%h/%h want=0/0/0", out_valid, out_data, out_tag); end
        total++; if (out_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", out_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_lost got=%b want=0", out_valid); end
        drive(1'b1, 3'd3, 32'h8000_0000, 5'd1, 5'd6);
        tick();
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_lat1 got=%b want=0", out_valid); end
        tick();
        total++; if (out_valid !== 1'b1 || out_data !== 32'h1 || out_tag !== 5'd6) begin bad++; $display("FAIL rst_after got=%b/%h/%h want=1/00000001/06", out_valid, out_data, out_tag); end
        tick();
    endtask

    task automatic test_comb_stage();
        cons_ready = 1'b1;
        drive(1'b1, 3'd2, 32'h8000_0000, 5'd4, 5'd12);
        #1;
        total++; if (p0_valid !== 1'b1 || p0_data !== 32'hF800_0000 || p0_tag !== 5'd12) begin bad++; $display("FAIL p0_result got=%b/%h/%h want=1/f8000000/0c", p0_valid, p0_data, p0_tag); end
        total++; if (p0_ready !== 1'b1) begin bad++; $display("FAIL p0_ready_hi got=%b want=1", p0_ready); end
        cons_ready = 1'b0;
        #1;
        total++; if (p0_ready !== 1'b0) begin bad++; $display("FAIL p0_ready_lo got=%b want=0", p0_ready); end
        flush = 1'b1;
        #1;
        total++; if (p0_valid !== 1'b0) begin bad++; $display("FAIL p0_flush got=%b want=0", p0_valid); end
        flush      = 1'b0;
        in_valid   = 1'b0;
        cons_ready = 1'b1;
        tick();
    endtask

    task automatic test_five_stages();
        cons_ready = 1'b1;
        in_valid   = 1'b0;
        flush      = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b1, 3'd4, 32'h1234_5678, 5'd20, 5'd21);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            total++; if (p5_valid !== 1'b0) begin bad++; $display("FAIL p5_early%0d got=%b want=0", c, p5_valid); end
            tick();
        end
        total++; if (p5_valid !== 1'b1 || p5_data !== 32'h4567_8123 || p5_tag !== 5'd21) begin bad++; $display("FAIL p5_result got=%b/%h/%h want=1/45678123/15", p5_valid, p5_data, p5_tag); end
        tick();
    endtask

    task automatic test_wide();
        cons_ready = 1'b1;
        drive(1'b1, 3'd4, 32'h0, 5'd0, 5'd9);
        in_data64 = 64'h1;
        in_amt64  = 6'd1;
        tick();
        in_op     = 3'd2;
        in_data64 = 64'h8000_0000_0000_0000;
        in_amt64  = 6'd63;
        in_tag    = 5'd10;
        total++; if (w64_valid !== 1'b1 || w64_data !== 64'h8000_0000_0000_0000 || w64_tag !== 5'd9) begin bad++; $display("FAIL w64_ror got=%b/%h/%h want=1/8000000000000000/09", w64_valid, w64_data, w64_tag); end
        tick();
        in_valid = 1'b0;
        total++; if (w64_valid !== 1'b1 || w64_data !== 64'hFFFF_FFFF_FFFF_FFFF || w64_tag !== 5'd10) begin bad++; $display("FAIL w64_sra got=%b/%h/%h want=1/ffffffffffffffff/0a", w64_valid, w64_data, w64_tag); end
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        flush      = 1'b0;
        cons_ready = 1'b1;
        in_data64  = '0;
        in_amt64   = '0;
        drive(1'b0, 3'd0, 32'h0, 5'd0, 5'd0);
        #2;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_directed_ops();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_comb_stage();
        test_five_stages();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
